int_log_unit: RTL

//   Integer logarithm engine, the inverse of the exponentiation block. Given base and

---
 rtl/int_log_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/int_log_unit.sv
// ---------------------------------------------------------------------------
// int_log_unit
//   Integer logarithm engine. For a base and a value it computes
//   expo = floor(log_base(value)), and flags whether base**expo == value.
//   An accumulator starting at 1 is multiplied by the base once per cycle
//   until the next product would exceed the value.
//
// Ports
//   clk    in   1       clock, all logic on posedge
//   reset  in   1       synchronous, active-high reset
//   start  in   1       request, sampled only while ready==1
//   base   in   BASE_W  base operand, latched on accept
//   value  in   VAL_W   value operand, latched on accept
//   expo   out  EXP_W   floor(log_base(value)), valid while ready==1
//   exact  out  1       1 when base**expo == value
//   err    out  1       1 when operands are illegal (base<2 or value==0)
//   ready  out  1       1 = idle / result valid, 0 = busy
// ---------------------------------------------------------------------------
module int_log_unit #(
    parameter int BASE_W = 8,
    parameter int VAL_W  = 32,
    parameter int EXP_W  = 6      // must be able to hold VAL_W-1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BASE_W-1:0] base,
    input  logic [VAL_W-1:0]  value,
    output logic [EXP_W-1:0]  expo,
    output logic              exact,
    output logic              err,
    output logic              ready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int PROD_W = VAL_W + BASE_W;

    logic [0:0]        r_state;
    logic              r_first;     // first RUN cycle: operand legality check
    logic [BASE_W-1:0] r_base;
    logic [VAL_W-1:0]  r_value;
    logic [VAL_W-1:0]  r_acc;
    logic [EXP_W-1:0]  r_cnt;
    logic [EXP_W-1:0]  r_expo;
    logic              r_exact;
    logic              r_err;
    logic              r_ready;

    logic [PROD_W-1:0] w_prod;
    logic              w_over;
    logic              w_illegal;

    // Both operands zero-extended to the full product width so the
    // comparison against value can never wrap (e.g. 255^5 vs 0xFFFFFFFF).
    assign w_prod    = {{BASE_W{1'b0}}, r_acc} * {{VAL_W{1'b0}}, r_base};
    assign w_over    = w_prod > {{BASE_W{1'b0}}, r_value};
    assign w_illegal = (r_base < BASE_W'(2)) || (r_value == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
            r_base  <= '0;
            r_value <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_expo  <= '0;
            r_exact <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base  <= base;
                        r_value <= value;
                        r_acc   <= VAL_W'(1);
                        r_cnt   <= '0;
                        r_expo  <= '0;
                        r_exact <= 1'b0;
                        r_err   <= 1'b0;
                        r_ready <= 1'b0;
                        r_first <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_first <= 1'b0;
                    // base 0/1 never overflows, so the legality check on the
                    // first cycle is the only exit for those operands.
                    if (r_first && w_illegal) begin
                        r_err   <= 1'b1;
                        r_expo  <= '0;
                        r_exact <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_over) begin
                        r_expo  <= r_cnt;
                        r_exact <= (r_acc == r_value);
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        // prod <= value here, so the low VAL_W bits hold it all
                        r_acc <= w_prod[VAL_W-1:0];
                        r_cnt <= r_cnt + EXP_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign expo  = r_expo;
    assign exact = r_exact;
    assign err   = r_err;
    assign ready = r_ready;

endmodule
